// File: rtl/cla_rr_scheduler.sv
// Round-robin scheduler sharing one 16-bit two-level carry-lookahead adder among NUM_REQ requesters,
// with locked multi-beat chains. Optional per-requester grant counters: define CLA_GRANT_CNT_EN.
module cla_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     rsp_last,
`ifdef CLA_GRANT_CNT_EN
  output logic [NUM_REQ*16-1:0]    grant_cnt,
`endif
  output logic                     dbg_state,
  output logic                     dbg_carry_q,
  output logic [ID_W-1:0]          dbg_rr_ptr
);

  // Handshake: a beat moves on requester i when req_valid[i] && req_ready[i]; a result moves
  // when rsp_valid && rsp_ready. The response register is the only buffer, so a beat is only
  // offered a ready when that register is empty or being drained in the same cycle.

  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_q, owner_q, grant, cand, sel_idx;
  logic              carry_q, found, slot_free, accept;
  logic              sel_cin, sel_last;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic [WIDTH-1:0]  p, g, c, sum;
  logic [3:0]        gp, gg;
  logic [4:0]        gc;

  assign slot_free = !rsp_valid || rsp_ready;

  // Rotating priority: search starts just after the last granted requester.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = ID_W'((int'(rr_q) + off) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    sel_idx   = grant;
    sel_cin   = 1'b0;
    case (state_q)
      ST_ARB: begin
        sel_idx = grant;
        sel_cin = req_cin[grant];
        if (rst_n && slot_free && found) req_ready[grant] = 1'b1;
      end
      ST_LOCK: begin
        sel_idx = owner_q;
        sel_cin = carry_q;
        if (rst_n && slot_free && req_valid[owner_q]) req_ready[owner_q] = 1'b1;
      end
      default: state_d = ST_ARB;
    endcase
    accept   = |(req_valid & req_ready);
    sel_last = req_last[sel_idx];
    if (accept) begin
      if (state_q == ST_ARB && !sel_last) state_d = ST_LOCK;
      if (state_q == ST_LOCK && sel_last) state_d = ST_ARB;
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Two-level CLA: 4-bit groups produce group P/G, the PG2C level resolves group carries.
  always_comb begin
    p  = sel_a ^ sel_b;
    g  = sel_a & sel_b;
    gp = '0;
    gg = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    gc[0] = sel_cin;
    gc[1] = gg[0] | (gp[0] & sel_cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & sel_cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & sel_cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & sel_cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum = p ^ c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      rr_q    <= ID_W'(NUM_REQ - 1);
      owner_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        carry_q <= gc[4];
        if (state_q == ST_ARB) begin
          rr_q    <= grant;
          owner_q <= grant;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_last  <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= sel_idx;
      rsp_sum   <= sum;
      rsp_cout  <= gc[4];
      rsp_last  <= sel_last;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef CLA_GRANT_CNT_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = cnt_q[i];
  end
`else
  // Grant counters are not built in this configuration.
`endif

  assign dbg_state   = state_q;
  assign dbg_carry_q = carry_q;
  assign dbg_rr_ptr  = rr_q;

endmodule

// File: tb/tb_cla_rr_scheduler.sv
// Directed bench for cla_rr_scheduler: reset, single add, fairness, chains, back-pressure, reset mid-chain.
module tb_cla_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic [NUM_REQ-1:0]       req_last;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic                     rsp_last;
  logic                     dbg_state;
  logic                     dbg_carry_q;
  logic [ID_W-1:0]          dbg_rr_ptr;
`ifdef CLA_GRANT_CNT_EN
  logic [NUM_REQ*16-1:0]    grant_cnt;
`endif

  logic [15:0] a_arr [NUM_REQ];
  logic [15:0] b_arr [NUM_REQ];
  logic [17:0] exp_q [$];

  int n_tests;
  int n_fail;

  cla_rr_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .req_last   (req_last),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_last   (rsp_last),
`ifdef CLA_GRANT_CNT_EN
    .grant_cnt  (grant_cnt),
`endif
    .dbg_state  (dbg_state),
    .dbg_carry_q(dbg_carry_q),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // Clock and operand packing
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*16 +: 16] = a_arr[i];
      req_b[i*16 +: 16] = b_arr[i];
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] i, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, input logic last);
    req_valid[i] = v;
    a_arr[i]     = a;
    b_arr[i]     = b;
    req_cin[i]   = cin;
    req_last[i]  = last;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_REQ; i++) drive(2'(i), 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [15:0] sum,
                         input logic cout, input logic last);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'h1);
    chk({tag, "_id"},    32'(rsp_id),    32'(id));
    chk({tag, "_sum"},   32'(rsp_sum),   32'(sum));
    chk({tag, "_cout"},  32'(rsp_cout),  32'(cout));
    chk({tag, "_last"},  32'(rsp_last),  32'(last));
  endtask

  int          order   [6]       = '{0, 1, 2, 3, 0, 1};
  logic [15:0] t3_sum  [NUM_REQ] = '{16'h1112, 16'h2223, 16'h3334, 16'h4445};

  initial begin
    logic [17:0] e;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_cin   = '0;
    req_last  = '0;
    for (int i = 0; i < NUM_REQ; i++) drive(2'(i), 1'b1, 16'h00AA, 16'h0055, 1'b0, 1'b1);

    // T1 reset with all requesters valid
    tick();
    tick();
    chk("t1_ready",  32'(req_ready),   32'h0);
    chk("t1_valid",  32'(rsp_valid),   32'h0);
    chk("t1_sum",    32'(rsp_sum),     32'h0);
    chk("t1_state",  32'(dbg_state),   32'h0);
    chk("t1_rrptr",  32'(dbg_rr_ptr),  32'h3);
    chk("t1_carry",  32'(dbg_carry_q), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("t1_first_grant", 32'(req_ready), 32'h1);

    // T2 single add on req0
    clear_all();
    drive(2'd0, 1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1);
    #1;
    chk("t2_ready", 32'(req_ready), 32'h1);
    tick();
    drive(2'd0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk_rsp("t2", 2'd0, 16'h5556, 1'b0, 1'b1);

    // T3 fairness with all valid and sink always ready
    do_reset();
    for (int i = 0; i < NUM_REQ; i++)
      drive(2'(i), 1'b1, 16'(32'h1111 * (i + 1)), 16'h0001, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t3_grant", 32'(req_ready), 32'(1 << order[k]));
      exp_q.push_back({2'(order[k]), t3_sum[order[k]]});
      tick();
      e = exp_q.pop_front();
      chk_rsp("t3", e[17:16], e[15:0], 1'b0, 1'b1);
    end
    chk("t3_sb_empty", 32'(exp_q.size()), 32'h0);
    clear_all();
    tick();

    // T4 chain on req2 while req1 waits
    do_reset();
    drive(2'd2, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    #1;
    chk("t4_grant_beat1", 32'(req_ready), 32'h4);
    tick();
    chk_rsp("t4_b1", 2'd2, 16'h0000, 1'b1, 1'b0);
    chk("t4_locked", 32'(dbg_state), 32'h1);
    drive(2'd1, 1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1);
    drive(2'd2, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    #1;
    chk("t4_owner_idle_ready", 32'(req_ready), 32'h0);
    tick();
    chk("t4_still_locked", 32'(dbg_state), 32'h1);
    chk("t4_drained", 32'(rsp_valid), 32'h0);
    drive(2'd2, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);
    #1;
    chk("t4_grant_beat2", 32'(req_ready), 32'h4);
    tick();
    chk_rsp("t4_b2", 2'd2, 16'h0001, 1'b0, 1'b1);
    chk("t4_unlocked", 32'(dbg_state), 32'h0);
    drive(2'd2, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    #1;
    chk("t4_grant_req1", 32'(req_ready), 32'h2);
    tick();
    chk_rsp("t4_req1", 2'd1, 16'h0008, 1'b0, 1'b1);

    // T5 back-pressure, then consume and accept on the same edge
    rsp_ready = 1'b0;
    drive(2'd1, 1'b1, 16'h0007, 16'h0002, 1'b0, 1'b1);
    drive(2'd0, 1'b1, 16'h0100, 16'h0200, 1'b1, 1'b1);
    #1;
    chk("t5_ready_stall", 32'(req_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_rsp("t5_hold", 2'd1, 16'h0008, 1'b0, 1'b1);
      chk("t5_ready_hold", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("t5_ready_release", 32'(req_ready), 32'h1);
    tick();
    chk_rsp("t5_next", 2'd0, 16'h0301, 1'b0, 1'b1);
    clear_all();
    tick();

    // T6 reset in the middle of a req3 chain
    do_reset();
    drive(2'd3, 1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0);
    #1;
    chk("t6_grant", 32'(req_ready), 32'h8);
    tick();
    chk_rsp("t6_b1", 2'd3, 16'h0000, 1'b1, 1'b0);
    chk("t6_locked", 32'(dbg_state), 32'h1);
    chk("t6_carry", 32'(dbg_carry_q), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_state", 32'(dbg_state),   32'h0);
    chk("t6_rst_carry", 32'(dbg_carry_q), 32'h0);
    chk("t6_rst_valid", 32'(rsp_valid),   32'h0);
    chk("t6_rst_ready", 32'(req_ready),   32'h0);
    chk("t6_rst_rrptr", 32'(dbg_rr_ptr),  32'h3);
    rst_n = 1'b1;
    drive(2'd3, 1'b1, 16'h0001, 16'h0001, 1'b1, 1'b1);
    #1;
    chk("t6_regrant", 32'(req_ready), 32'h8);
    tick();
    chk_rsp("t6_restart", 2'd3, 16'h0003, 1'b0, 1'b1);
    chk("t6_arb", 32'(dbg_state), 32'h0);
    clear_all();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
